// File: rtl/mem_dma.sv
// Single-channel memory-to-memory copy engine: read, latch, write, one byte every 3 cycles.
// Optional running byte checksum output enabled by defining MEM_DMA_CHECKSUM_EN.
module mem_dma #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {StIdle, StRead, StLatch, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d, done_q, done_d, we_q, we_d, re_q, re_d;
    logic [ADDR_W:0]   idx_inc;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // One extra bit so the last-byte compare never wraps.
    assign idx_inc = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
`ifdef MEM_DMA_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
`ifdef MEM_DMA_CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if (len != '0) begin
                        src_d   = src;
                        dst_d   = dst;
                        len_d   = len;
                        idx_d   = '0;
                        addr_d  = src;
                        re_d    = 1'b1;
                        state_d = StRead;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                state_d = StLatch;
            end
            StLatch: begin
                data_d  = mem_out;
                addr_d  = dst_q + idx_q;
                we_d    = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                idx_d = idx_inc[ADDR_W-1:0];
`ifdef MEM_DMA_CHECKSUM_EN
                sum_d = sum_q + data_q;
`endif
                if (idx_inc < {1'b0, len_q}) begin
                    addr_d  = src_q + idx_inc[ADDR_W-1:0];
                    re_d    = 1'b1;
                    state_d = StRead;
                end else begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
`ifdef MEM_DMA_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            re_q    <= re_d;
`ifdef MEM_DMA_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_we   = we_q;
    assign mem_re   = re_q;
    assign mem_addr = addr_q;
    assign mem_in   = data_q;
`ifdef MEM_DMA_CHECKSUM_EN
    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: behavioural memory plus a byte-array copy model.
module tb_mem_dma;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] src = '0, dst = '0, len = '0;
    logic          busy, done, mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in, mem_out;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [4096];
    logic [DW-1:0] ref_mem [4096];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int n_cmp = 0, n_bad = 0;
    int overlap_cnt = 0, we_cnt = 0, re_cnt = 0;

    mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
`ifdef MEM_DMA_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; also the only place the array is written.
    always @(posedge clk) begin
        if (mem_re) mem_out <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_in;
        if (pre_we) mem[pre_addr] = pre_data;
    end

    always @(negedge clk) begin
        if (mem_we && mem_re) begin
            overlap_cnt++;
            $display("FAIL we_re_overlap: mem_we=%b mem_re=%b required not both high at %0t",
                     mem_we, mem_re, $time);
        end
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
        step();
        pre_we = 1'b0;
    endtask

    // Reference: strictly forward byte copy with address wrap; returns byte sum.
    task automatic ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] l, output logic [DW-1:0] sum);
        sum = '0;
        for (int i = 0; i < int'(l); i++) begin
            logic [AW-1:0] ra, wa;
            ra = s + AW'(i);
            wa = d + AW'(i);
            ref_mem[wa] = ref_mem[ra];
            sum = sum + ref_mem[ra];
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Issue one copy; optionally re-pulse start (different src) at cycle `poke`.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] l, input int poke,
                            output int done_at, output int ndone,
                            output logic busy_first, output logic busy_after);
        start = 1'b1; src = s; dst = d; len = l;
        step();
        start = 1'b0; src = AW'($urandom); dst = AW'($urandom); len = AW'($urandom);
        busy_first = busy;
        busy_after = 1'b1;
        done_at = -1;
        ndone = 0;
        for (int c = 1; c <= 3 * int'(l) + 12; c++) begin
            if (c > 1) step();
            if (c == poke) begin
                start = 1'b1; src = s + 1'b1;
            end else if (c == poke + 1) begin
                start = 1'b0;
            end
            if (done_at >= 0 && c == done_at + 1) busy_after = busy;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if ({mem_we, mem_re} !== 2'b00) begin n_bad++; $display("FAIL reset_we_re: got %b want 00", {mem_we, mem_re}); end
        n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
        n_cmp++; if (mem_in !== '0) begin n_bad++; $display("FAIL reset_in: got %h want 00", mem_in); end
        reset = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int da, nd; logic bf, ba; logic [DW-1:0] sum;
        poke_mem(12'h000, 8'hAA);
        poke_mem(12'h001, 8'hBB);
        ref_copy(12'h000, 12'h400, 12'd2, sum);
        run_copy(12'h000, 12'h400, 12'd2, 0, da, nd, bf, ba);
        n_cmp++; if (da !== 7) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 7", da); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", nd); end
        n_cmp++; if (bf !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", bf); end
        n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", ba); end
        n_cmp++; if (mem[12'h400] !== 8'hAA) begin n_bad++; $display("FAIL basic_byte0: got %h want AA", mem[12'h400]); end
        n_cmp++; if (mem[12'h401] !== 8'hBB) begin n_bad++; $display("FAIL basic_byte1: got %h want BB", mem[12'h401]); end
        n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL basic_mem: got %0d differing bytes want 0", mem_diff()); end
`ifdef MEM_DMA_CHECKSUM_EN
        n_cmp++; if (checksum !== 8'h65) begin n_bad++; $display("FAIL basic_checksum: got %h want 65", checksum); end
`endif
    endtask

    task automatic test_zero_len();
        int da, nd, we0, re0; logic bf, ba;
        we0 = we_cnt; re0 = re_cnt;
        run_copy(AW'($urandom), AW'($urandom), 12'd0, 0, da, nd, bf, ba);
        n_cmp++; if (da !== 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", da); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", nd); end
        n_cmp++; if ((we_cnt - we0) + (re_cnt - re0) !== 0) begin n_bad++; $display("FAIL zero_mem_access: got %0d accesses want 0", (we_cnt - we0) + (re_cnt - re0)); end
        n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL zero_mem: got %0d differing bytes want 0", mem_diff()); end
`ifdef MEM_DMA_CHECKSUM_EN
        n_cmp++; if (checksum !== 8'h00) begin n_bad++; $display("FAIL zero_checksum: got %h want 00", checksum); end
`endif
    endtask

    task automatic test_wrap();
        int da, nd; logic bf, ba; logic [DW-1:0] sum;
        poke_mem(12'hFFF, 8'hDD);
        poke_mem(12'h000, 8'hEE);
        ref_copy(12'hFFF, 12'h7FF, 12'd2, sum);
        run_copy(12'hFFF, 12'h7FF, 12'd2, 0, da, nd, bf, ba);
        n_cmp++; if (mem[12'h7FF] !== 8'hDD) begin n_bad++; $display("FAIL wrap_byte0: got %h want DD", mem[12'h7FF]); end
        n_cmp++; if (mem[12'h800] !== 8'hEE) begin n_bad++; $display("FAIL wrap_byte1: got %h want EE", mem[12'h800]); end
        n_cmp++; if (da !== 7) begin n_bad++; $display("FAIL wrap_done_cycle: got %0d want 7", da); end
        n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL wrap_mem: got %0d differing bytes want 0", mem_diff()); end
    endtask

    task automatic test_restart_ignored();
        int da, nd; logic bf, ba; logic [DW-1:0] sum;
        // Second start arrives mid-copy, then in the DONE cycle.
        for (int k = 0; k < 2; k++) begin
            ref_copy(12'h100, 12'h900, 12'd3, sum);
            run_copy(12'h100, 12'h900, 12'd3, (k == 0) ? 4 : 10, da, nd, bf, ba);
            n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL restart_done_count[%0d]: got %0d want 1", k, nd); end
            n_cmp++; if (da !== 10) begin n_bad++; $display("FAIL restart_done_cycle[%0d]: got %0d want 10", k, da); end
            n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL restart_mem[%0d]: got %0d differing bytes want 0", k, mem_diff()); end
        end
    endtask

    task automatic test_reset_mid_copy();
        int nd, we0; logic [DW-1:0] sum;
        we0 = we_cnt;
        ref_copy(12'h200, 12'hA00, 12'd1, sum);
        start = 1'b1; src = 12'h200; dst = 12'hA00; len = 12'd3;
        step();
        start = 1'b0;
        for (int c = 2; c <= 4; c++) step();
        reset = 1'b1;
        step();
        n_cmp++; if ({busy, done, mem_we, mem_re} !== 4'b0000) begin n_bad++; $display("FAIL abort_ctrl: got %b want 0000", {busy, done, mem_we, mem_re}); end
        n_cmp++; if ({mem_addr, mem_in} !== '0) begin n_bad++; $display("FAIL abort_addr_in: got %h/%h want 000/00", mem_addr, mem_in); end
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done === 1'b1) nd++;
        end
        n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses want 0", nd); end
        n_cmp++; if (we_cnt - we0 !== 1) begin n_bad++; $display("FAIL abort_writes: got %0d want 1", we_cnt - we0); end
        n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL abort_mem: got %0d differing bytes want 0", mem_diff()); end
`ifdef MEM_DMA_CHECKSUM_EN
        n_cmp++; if (checksum !== 8'h00) begin n_bad++; $display("FAIL abort_checksum: got %h want 00", checksum); end
`endif
    endtask

    task automatic test_random();
        int da, nd, poke; logic bf, ba; logic [DW-1:0] sum;
        logic [AW-1:0] s, d, l;
        for (int it = 0; it < 14; it++) begin
            s = AW'($urandom);
            d = ($urandom_range(0, 2) == 0) ? s + AW'($urandom_range(0, 3)) : AW'($urandom);
            l = AW'($urandom_range(0, 9));
            poke = (l != 0) ? $urandom_range(2, 3 * int'(l) + 1) : 0;
            ref_copy(s, d, l, sum);
            run_copy(s, d, l, poke, da, nd, bf, ba);
            n_cmp++; if (da !== 3 * int'(l) + 1) begin n_bad++; $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", it, da, 3 * int'(l) + 1); end
            n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL rand_done_count[%0d]: got %0d want 1", it, nd); end
            n_cmp++; if ({bf, ba} !== 2'b10) begin n_bad++; $display("FAIL rand_busy[%0d]: got %b want 10", it, {bf, ba}); end
            n_cmp++; if (mem_diff() !== 0) begin n_bad++; $display("FAIL rand_mem[%0d]: got %0d differing bytes want 0", it, mem_diff()); end
`ifdef MEM_DMA_CHECKSUM_EN
            n_cmp++; if (checksum !== sum) begin n_bad++; $display("FAIL rand_checksum[%0d]: got %h want %h", it, checksum, sum); end
`endif
        end
        n_cmp++; if (overlap_cnt !== 0) begin n_bad++; $display("FAIL we_re_exclusive: got %0d overlaps want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 4096; i++) poke_mem(AW'(i), DW'($urandom));
        test_basic();
        test_zero_len();
        test_wrap();
        test_restart_ignored();
        test_reset_mid_copy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory address width (bits [ADDR_W-1:ADDR_W-2] select one of 4 banks).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 SHALL have port src  input  ADDR_W  source start address, captured on accepted start.
REQ-007 SHALL have port dst  input  ADDR_W  destination start address, captured on accepted start.
REQ-008 SHALL have port len  input  ADDR_W  byte count, captured on accepted start; 0 = no transfer.
REQ-009 SHALL have port busy  output  1  high from cycle after accepted start until DONE exits.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_we  output  1  to memory we.
REQ-012 SHALL have port mem_re  output  1  to memory re.
REQ-013 SHALL have port mem_addr  output  ADDR_W  to memory addr.
REQ-014 SHALL have port mem_in  output  DATA_W  to memory in (write data).
REQ-015 SHALL have port mem_out  input  DATA_W  from memory out; valid the cycle after mem_re sampled high.

Function
REQ-016 SHALL implement states IDLE, READ, LATCH, WRITE, DONE; all outputs registered.
REQ-017 IDLE: start=1 with len!=0 -> capture src/dst/len, clear index, go READ; start=1 with len=0 -> go DONE.
REQ-018 READ (1 cycle): mem_re=1, mem_we=0, mem_addr=src+index; -> LATCH.
REQ-019 LATCH (1 cycle): mem_re=0, mem_we=0; capture mem_out into data register at end of cycle; -> WRITE.
REQ-020 WRITE (1 cycle): mem_we=1, mem_re=0, mem_addr=dst+index, mem_in=data register; increment index; -> READ if index+1<len, else DONE.
REQ-021 DONE (1 cycle): done=1, busy=0 on exit; -> IDLE.
REQ-022 mem_we and mem_re SHALL never be high in the same cycle.
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_W (0xFFF+1 wraps to 0x000, crossing bank 3 -> bank 0).
REQ-024 Throughput 3 cycles/byte; done SHALL assert exactly 3*len+1 cycles after the accepted start edge (len=0: 1 cycle).
REQ-025 start while busy or in DONE SHALL be ignored; src/dst/len changes while busy SHALL have no effect.
REQ-026 Overlapping ranges SHALL be copied strictly forward (ascending index), no hazard handling.
REQ-027 mem_addr and mem_in SHALL hold last values when no access is in progress; mem_we/mem_re low.

Reset
REQ-028 reset=1 at any clock edge SHALL force IDLE; busy, done, mem_we, mem_re = 0; mem_addr, mem_in, index, data register = 0.
REQ-029 reset mid-copy SHALL abort immediately with no further memory access; bytes already written remain; no done pulse.

Configuration
REQ-030 Macro MEM_DMA_CHECKSUM_EN defined: output checksum DATA_W, cleared on accepted start and reset, updated in WRITE to (checksum + data) mod 2^DATA_W, stable from DONE until next accepted start.
REQ-031 Macro MEM_DMA_CHECKSUM_EN undefined: no checksum port or logic; all other behaviour identical.

Verification
REQ-032 Memory preloaded mem0[0]=AA, mem0[1]=BB; start src=0x000 dst=0x400 len=2 -> mem1[0]=AA, mem1[1]=BB, done 7 cycles after start; checksum 0x65 when enabled.
REQ-033 start len=0 -> done 1 cycle after start, no mem_we/mem_re ever asserted.
REQ-034 src=0xFFF dst=0x7FF len=2, mem3[0x3FF]=DD, mem0[0]=EE -> mem1[0x3FF]=DD, mem2[0]=EE (wrap).
REQ-035 start pulsed again during copy with different src -> ignored; single done; original copy result only.
REQ-036 reset asserted on the 4th cycle of a len=3 copy -> byte 0 written, bytes 1-2 not written, outputs zero next cycle, no done.
REQ-037 Every cycle of all scenarios: assert !(mem_we && mem_re) and busy==0 whenever state is IDLE.
